// File: rtl/regfile_2r1w.sv
// 32 x BITS integer register file: two combinational read ports, one synchronous write port,
// entry ZERO_REG hardwired to zero. Define REGFILE_WRITE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_2r1w #(
    parameter int unsigned BITS     = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [BITS-1:0]   WriteData,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [BITS-1:0]   ReadData1,
    output logic [BITS-1:0]   ReadData2
);

    localparam int unsigned NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [BITS-1:0] regs_q [NREG];
    logic [BITS-1:0] regs_d [NREG];
    logic [NREG-1:0] wr_en;
    logic            wr_valid;

    // A write to the zero register never reaches the decoder, so that entry stays at reset value.
    assign wr_valid = RegWrite && (WriteRegister != ZERO_IDX);

    always_comb begin
        wr_en = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            wr_en[i] = wr_valid && (WriteRegister == ADDR_W'(i));
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            regs_d[i] = wr_en[i] ? WriteData : regs_q[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    function automatic logic [BITS-1:0] read_port(input logic [ADDR_W-1:0] idx);
        logic [BITS-1:0] val;
        val = (idx == ZERO_IDX) ? '0 : regs_q[idx];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (!reset && wr_valid && (WriteRegister == idx)) begin
            val = WriteData;
        end
`endif
        return val;
    endfunction

    always_comb begin
        ReadData1 = read_port(ReadRegister1);
        ReadData2 = read_port(ReadRegister2);
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Randomized self-checking bench for regfile_2r1w against an array-based reference model.
module tb_regfile_2r1w;

    localparam int ZERO = 31;
`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    logic [63:0] mem [32];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    regfile_2r1w #(.BITS(64), .ADDR_W(5), .ZERO_REG(31)) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] expect_rd(input logic [4:0] idx);
        if (reset) return 64'd0;
        if (BYP && RegWrite && WriteRegister == idx && idx != 5'(ZERO)) return WriteData;
        if (idx == 5'(ZERO)) return 64'd0;
        return mem[idx];
    endfunction

    // Drive one cycle of inputs, check both ports before the edge, then advance the model.
    task automatic step(input logic we, input logic [4:0] wr, input logic [63:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2, input string tag);
        @(negedge clk);
        RegWrite = we; WriteRegister = wr; WriteData = wd;
        ReadRegister1 = r1; ReadRegister2 = r2;
        #1;
        chk({tag, "_rd1"}, ReadData1, expect_rd(r1));
        chk({tag, "_rd2"}, ReadData2, expect_rd(r2));
        @(posedge clk);
        if (!reset && we && wr != 5'(ZERO)) mem[wr] = wd;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 5'($urandom), {$urandom, $urandom}, 5'(i), 5'(31 - i), tag);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 64'd0;
        reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd17;
        repeat (2) @(posedge clk);
        #1;
        chk("por_rd1", ReadData1, 64'd0);
        chk("por_rd2", ReadData2, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Asynchronous reset clears a freshly written entry between edges.
        step(1'b1, 5'd5, 64'hDEADBEEF_CAFEF00D, 5'd5, 5'd5, "wr_x5");
        @(negedge clk);
        RegWrite = 1'b0; ReadRegister1 = 5'd5; ReadRegister2 = 5'd5;
        #1;
        chk("x5_before_rst", ReadData1, 64'hDEADBEEF_CAFEF00D);
        #1 reset = 1'b1;
        #1;
        chk("rst_async", ReadData1, 64'd0);
        for (int i = 0; i < 32; i++) mem[i] = 64'd0;
        for (int i = 0; i < 32; i++) begin
            RegWrite = 1'b1; WriteRegister = 5'(i); WriteData = '1;
            ReadRegister1 = 5'(i); ReadRegister2 = 5'(31 - i);
            #1;
            chk("rst_rd1", ReadData1, 64'd0);
            chk("rst_rd2", ReadData2, 64'd0);
        end
        @(negedge clk);
        RegWrite = 1'b0;
        reset = 1'b0;
        check_all("post_rst");

        // Full sweep; each write visible exactly one edge after issue.
        for (int i = 0; i < 31; i++) begin
            step(1'b1, 5'(i), {32'hA5A5_0000 + 32'(i), 32'(i)}, 5'(i), 5'(30 - i), "sweep_wr");
            #1;
            chk("sweep_vis", ReadData1, {32'hA5A5_0000 + 32'(i), 32'(i)});
        end
        for (int i = 0; i < 31; i++) begin
            step(1'b0, 5'd0, 64'd0, 5'(i), 5'(30 - i), "sweep_rd");
        end

        // Zero register ignores writes.
        step(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, "zr_wr");
        #1;
        chk("zr_post1", ReadData1, 64'd0);
        chk("zr_post2", ReadData2, 64'd0);

        // Write disable holds everything.
        step(1'b1, 5'd7, 64'h1234, 5'd7, 5'd0, "x7_wr");
        repeat (3) step(1'b0, 5'd7, 64'h9999, 5'd7, 5'd7, "wdis");
        check_all("wdis_all");

        // Read-during-write on the same index.
        step(1'b1, 5'd3, 64'h11, 5'd3, 5'd3, "x3_wr");
        step(1'b1, 5'd3, 64'h22, 5'd3, 5'd3, "rdw_pre");
        #1;
        chk("rdw_post1", ReadData1, 64'h22);
        chk("rdw_post2", ReadData2, 64'h22);

        // Back-to-back writes.
        step(1'b1, 5'd1, 64'h1, 5'd1, 5'd2, "b2b1");
        step(1'b1, 5'd1, 64'h2, 5'd1, 5'd2, "b2b2");
        step(1'b1, 5'd2, 64'h3, 5'd1, 5'd2, "b2b3");
        step(1'b0, 5'd0, 64'd0, 5'd1, 5'd2, "b2b_rd");
        chk("b2b_x1", mem[1], 64'h2);
        chk("b2b_x2", mem[2], 64'h3);
        check_all("b2b_all");

        // Random traffic, biased toward read/write index collisions.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wr, r1, r2;
            wr = 5'($urandom);
            r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom);
            r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom);
            step(1'($urandom), wr, {$urandom, $urandom}, r1, r2, "rnd");
        end
        check_all("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
